// File: rtl/uart_io_bridge_pkg.sv
// ----------------------------------------------------------------------------
// uart_io_bridge_pkg: frame command/response codes and bridge state encoding.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_io_bridge_pkg;

  localparam logic [7:0] C_CMD_WRITE = 8'h57;
  localparam logic [7:0] C_CMD_READ  = 8'h52;
  localparam logic [7:0] C_RSP_ACK   = 8'h06;
  localparam logic [7:0] C_RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_REQ    = 3'd3,
    ST_ACCESS = 3'd4,
    ST_RDWAIT = 3'd5,
    ST_RESP   = 3'd6
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == C_CMD_WRITE) || (b == C_CMD_READ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_io_bridge_if.sv
// ----------------------------------------------------------------------------
// uart_io_bridge_if: UART byte handshakes and I/O bus signals of the bridge.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_io_bridge_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        tx_busy;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        io_wr;
  logic        io_rd;
  logic [31:0] mem_addr;
  logic [31:0] dout;
  logic [31:0] io_din;

  modport master (
    input  rx_valid, rx_data, tx_busy, bus_gnt, io_din,
    output rx_rd, tx_wr, tx_data, bus_req, io_wr, io_rd, mem_addr, dout
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, bus_gnt, io_din,
    input  rx_rd, tx_wr, tx_data, bus_req, io_wr, io_rd, mem_addr, dout
  );
endinterface

`default_nettype wire

// File: rtl/uart_io_bridge_tx_seq.sv
// ----------------------------------------------------------------------------
// bridge_tx_seq: sends 1..4 response bytes MSB-first, paced by tx_busy.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bridge_tx_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  count,
  input  logic [31:0] word,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic        active_q, active_d;
  logic [2:0]  rem_q, rem_d;
  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  hist_q, hist_d;

  // hist_q remembers tx_wr of the last two cycles so writes are >= 3 cycles apart
  assign tx_wr   = active_q && !tx_busy && (hist_q == 2'b00) && !reset;
  assign done    = tx_wr && (rem_q == 3'd1);
  assign tx_data = shreg_q[31:24];

  always_comb begin
    active_d = active_q;
    rem_d    = rem_q;
    shreg_d  = shreg_q;
    hist_d   = {hist_q[0], tx_wr};
    if (start && !active_q) begin
      active_d = 1'b1;
      rem_d    = count;
      shreg_d  = word;
    end else if (tx_wr) begin
      shreg_d = {shreg_q[23:0], 8'h00};
      rem_d   = rem_q - 3'd1;
      if (rem_q == 3'd1) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      rem_q    <= 3'd0;
      shreg_q  <= 32'h0;
      hist_q   <= 2'b00;
    end else begin
      active_q <= active_d;
      rem_q    <= rem_d;
      shreg_q  <= shreg_d;
      hist_q   <= hist_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_io_bridge.sv
// ----------------------------------------------------------------------------
// uart_io_bridge: decodes UART W/R frames into single I/O bus accesses.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_io_bridge #(
  parameter int TIMEOUT = 25000000,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_io_bridge_if.master  bus
);
  import uart_io_bridge_pkg::*;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          rx_rd_q, rx_rd_d;

  logic          take;
  logic          w_bus_req;
  logic          w_io_wr;
  logic          w_io_rd;
  logic          seq_start;
  logic [2:0]    seq_count;
  logic [31:0]   seq_word;
  logic          seq_done;

  // A byte is taken once; the following rx_rd cycle blocks a second take.
  assign take = bus.rx_valid && !rx_rd_q &&
                ((state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA));

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tmo_d     = '0;
    lat_d     = lat_q;
    rx_rd_d   = take;
    w_bus_req = 1'b0;
    w_io_wr   = 1'b0;
    w_io_rd   = 1'b0;
    seq_start = 1'b0;
    seq_count = 3'd1;
    seq_word  = {C_RSP_NAK, 24'h0};

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (is_cmd(bus.rx_data)) begin
            state_d = ST_ADDR;
            bcnt_d  = 2'd0;
            is_wr_d = (bus.rx_data == C_CMD_WRITE);
          end else begin
            state_d   = ST_RESP;
            seq_start = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (take) begin
          addr_d = {addr_q[23:0], bus.rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = is_wr_q ? ST_DATA : ST_REQ;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_RESP;
          seq_start = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (take) begin
          data_d = {data_q[23:0], bus.rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = ST_REQ;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_RESP;
          seq_start = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_REQ: begin
        w_bus_req = 1'b1;
        if (bus.bus_gnt) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_bus_req = 1'b1;
        // A grant lost between REQ and ACCESS sends us back to wait again.
        if (!bus.bus_gnt) begin
          state_d = ST_REQ;
        end else if (is_wr_q) begin
          w_io_wr   = 1'b1;
          state_d   = ST_RESP;
          seq_start = 1'b1;
          seq_word  = {C_RSP_ACK, 24'h0};
        end else begin
          w_io_rd = 1'b1;
          state_d = ST_RDWAIT;
          lat_d   = '0;
        end
      end
      ST_RDWAIT: begin
        w_bus_req = 1'b1;
        if (lat_q == LAT_LAST) begin
          state_d   = ST_RESP;
          seq_start = 1'b1;
          seq_count = 3'd4;
          seq_word  = bus.io_din;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_RESP: begin
        if (seq_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= 2'd0;
      is_wr_q <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      tmo_q   <= '0;
      lat_q   <= '0;
      rx_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  // Strobes are masked while reset is asserted so an aborted frame never leaks one.
  assign bus.rx_rd    = rx_rd_q && !reset;
  assign bus.bus_req  = w_bus_req && !reset;
  assign bus.io_wr    = w_io_wr && !reset;
  assign bus.io_rd    = w_io_rd && !reset;
  assign bus.mem_addr = addr_q;
  assign bus.dout     = data_q;

  bridge_tx_seq u_tx_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (seq_start),
    .count   (seq_count),
    .word    (seq_word),
    .tx_busy (bus.tx_busy),
    .tx_wr   (bus.tx_wr),
    .tx_data (bus.tx_data),
    .done    (seq_done)
  );

endmodule

`default_nettype wire

// File: doc/uart_io_bridge.md
UART_IO_BRIDGE -- requirements
Module: uart_io_bridge

Interface
REQ-001 Parameter TIMEOUT, default 25000000, inter-byte timeout in clk cycles (1 s at 25 MHz).
REQ-002 Parameter RD_LAT, default 1, cycles from io_rd pulse to io_din valid.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rx_valid  in  1  UART receiver holds a byte.
REQ-006 rx_data  in  8  received byte.
REQ-007 rx_rd  out  1  one-cycle pulse; consumes the byte.
REQ-008 tx_busy  in  1  UART transmitter busy.
REQ-009 tx_wr  out  1  one-cycle pulse; loads tx_data.
REQ-010 tx_data  out  8  byte to transmit.
REQ-011 bus_req  out  1  requests the I/O bus.
REQ-012 bus_gnt  in  1  I/O bus granted to the bridge.
REQ-013 io_wr  out  1  one-cycle I/O write strobe.
REQ-014 io_rd  out  1  one-cycle I/O read strobe.
REQ-015 mem_addr  out  32  I/O address.
REQ-016 dout  out  32  I/O write data.
REQ-017 io_din  in  32  I/O read data.

Function
REQ-018 Frame format: command byte, then 4 address bytes MSB-first; 'W' (0x57) adds 4 data bytes MSB-first; 'R' (0x52) adds none.
REQ-019 States: IDLE, ADDR, DATA, REQ, ACCESS, RDWAIT, RESP.
REQ-020 Byte consumption: rx_rd pulses in the cycle after rx_valid is seen in IDLE, ADDR or DATA; at most one pulse per 2 cycles.
REQ-021 IDLE: 0x57 or 0x52 -> ADDR, byte counter cleared; any other byte -> RESP with the single byte NAK 0x15.
REQ-022 ADDR: shift the byte into the address register; after the 4th byte -> DATA for 'W', REQ for 'R'.
REQ-023 DATA: shift the byte into the data register; after the 4th byte -> REQ.
REQ-024 REQ: bus_req high; mem_addr and dout stable; on bus_gnt high -> ACCESS.
REQ-025 ACCESS: exactly one cycle of io_wr ('W') or io_rd ('R') with bus_gnt high; bus_req stays high; 'W' -> RESP with ACK 0x06; 'R' -> RDWAIT.
REQ-026 RDWAIT: wait RD_LAT cycles after the io_rd cycle, capture io_din, drop bus_req, then -> RESP with 4 bytes MSB-first.
REQ-027 bus_req falls in the cycle after the io_wr pulse; mem_addr and dout hold until the next frame.
REQ-028 RESP transmit rule: tx_wr only when tx_busy is low and no tx_wr occurred in the previous 2 cycles; after the last byte -> IDLE.
REQ-029 Timeout: a counter resets on each consumed byte; reaching TIMEOUT in ADDR or DATA aborts to RESP with NAK 0x15; the address and data registers are left unchanged.
REQ-030 No timeout in REQ, ACCESS or RESP; the grant wait is unbounded.
REQ-031 Bytes arriving during REQ..RESP are not consumed (rx_rd low); they are handled in IDLE afterwards.
REQ-032 bus_gnt dropping during REQ: bridge stays in REQ; no strobe without grant.
REQ-033 io_wr and io_rd are never high in the same cycle.

Reset
REQ-034 On reset: state IDLE; rx_rd, tx_wr, bus_req, io_wr and io_rd at 0; tx_data, mem_addr and dout at 0; counters at 0.
REQ-035 Reset mid-frame or mid-response discards the frame with no strobe and no further tx_wr.

Structure
REQ-036 A shared package holds the command constants (0x57, 0x52), the response constants (0x06, 0x15) and the state enumeration.
REQ-037 One sub-module, bridge_tx_seq, serialises up to 4 response bytes under the REQ-028 rule; all other logic lives in the top FSM.

Verification
REQ-038 Write frame 57 00 00 04 04 00 00 00 A5, bus_gnt tied high -> one io_wr, mem_addr=0x00000404, dout=0x000000A5, then tx byte 06.
REQ-039 Read frame 52 00 00 10 08, io_din=0x000E1000 one cycle after io_rd -> tx bytes 00 0E 10 00 in order.
REQ-040 Byte 0x41 in IDLE -> tx 15, no bus_req; the following valid frame is processed normally.
REQ-041 57 00 00 then silence, TIMEOUT=100 -> NAK 15 at the 100th idle cycle; no io_wr.
REQ-042 Grant held low for 50 cycles during a read -> bus_req high throughout, io_rd only after grant, response data correct.
REQ-043 Reset asserted after the 6th byte of a write frame -> no io_wr, no tx_wr, outputs at reset values; the next frame succeeds.
